// File: rtl/risc_datapath.sv
// 16-bit single-cycle RISC datapath: PC, instruction/data memories, 8x16 register
// file, flag-generating adder ALU and output register, steered by an external controller.
module risc_datapath #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flag_HLT,
  input  logic        test_normal,
  input  logic        ext_instr_we,
  input  logic [15:0] ext_instr_addr,
  input  logic [15:0] ext_instr_data,
  input  logic        ext_data_write_en,
  input  logic [15:0] ext_data_addr,
  input  logic [15:0] ext_data_data,
  output logic [15:0] mem_instr_out,
  input  logic        Src_Read_B,
  input  logic        Src_ALU_B,
  input  logic        ADC,
  input  logic        SUB,
  input  logic        SBB,
  input  logic        JMP,
  input  logic        flag_label_PC,
  input  logic        flag_Rm_PC,
  input  logic        flag_Rd_PC,
  input  logic        BRANCH,
  input  logic        data_write_en,
  input  logic        flag_mem_RF,
  input  logic        flag_ALU_RF,
  input  logic        flag_Rm_RF,
  input  logic        flag_PC_RF,
  input  logic        LHI,
  input  logic        LLI,
  input  logic        RF_write_en,
  input  logic        flag_OutR,
  output logic        Pre_C,
  output logic        Pre_V,
  output logic        Pre_Z,
  output logic        Pre_N,
  output logic [15:0] OutR
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [15:0]    imem_r [IMEM_DEPTH];
  logic [15:0]    dmem_r [DMEM_DEPTH];
  logic [15:0]    rf_r   [8];
  logic [15:0]    pc_r;
  logic [15:0]    outr_r;
  logic           c_r;

  logic [IAW-1:0] imem_addr_s;
  logic [15:0]    instr_s;
  logic [2:0]     rd_s;
  logic [2:0]     rn_s;
  logic [2:0]     rm_s;
  logic [4:0]     imm5_s;
  logic [7:0]     imm8_s;
  logic [10:0]    imm11_s;
  logic [2:0]     rb_addr_s;
  logic [15:0]    port_a_s;
  logic [15:0]    port_b_s;
  logic [15:0]    rm_val_s;
  logic [15:0]    alu_b_s;
  logic [15:0]    alu_opnd_s;
  logic           alu_cin_s;
  logic [16:0]    alu_sum_s;
  logic [15:0]    alu_res_s;
  logic [DAW-1:0] dmem_addr_s;
  logic [15:0]    dmem_rdata_s;
  logic [15:0]    dmem_wdata_s;
  logic           dmem_we_s;
  logic           imem_we_s;
  logic           rf_we_s;
  logic           run_s;
  logic [15:0]    wb_data_s;
  logic [15:0]    pc_inc_s;
  logic [15:0]    next_pc_s;
  logic           unused_s;

  assign imem_addr_s   = test_normal ? ext_instr_addr[IAW-1:0] : pc_r[IAW-1:0];
  assign instr_s       = imem_r[imem_addr_s];
  assign mem_instr_out = instr_s;

  assign rd_s    = instr_s[10:8];
  assign rn_s    = instr_s[7:5];
  assign rm_s    = instr_s[4:2];
  assign imm5_s  = instr_s[4:0];
  assign imm8_s  = instr_s[7:0];
  assign imm11_s = instr_s[10:0];

  // An Rd-relative jump reads its target through port B, so it also steers the B address.
  assign rb_addr_s = (Src_Read_B || flag_Rd_PC) ? rd_s : rm_s;
  assign port_a_s  = rf_r[rn_s];
  assign port_b_s  = rf_r[rb_addr_s];
  assign rm_val_s  = rf_r[rm_s];

  // ALU operand/carry selection: subtraction is addition of the inverted operand.
  always_comb begin
    alu_b_s = Src_ALU_B ? {11'd0, imm5_s} : port_b_s;
    if (SUB) begin
      alu_opnd_s = ~alu_b_s;
      alu_cin_s  = 1'b1;
    end else if (SBB) begin
      alu_opnd_s = ~alu_b_s;
      alu_cin_s  = c_r;
    end else if (ADC) begin
      alu_opnd_s = alu_b_s;
      alu_cin_s  = c_r;
    end else begin
      alu_opnd_s = alu_b_s;
      alu_cin_s  = 1'b0;
    end
  end

  assign alu_sum_s = {1'b0, port_a_s} + {1'b0, alu_opnd_s} + {16'd0, alu_cin_s};
  assign alu_res_s = alu_sum_s[15:0];

  assign Pre_C = alu_sum_s[16];
  assign Pre_V = (port_a_s[15] == alu_opnd_s[15]) && (alu_res_s[15] != port_a_s[15]);
  assign Pre_Z = (alu_res_s == 16'd0);
  assign Pre_N = alu_res_s[15];

  assign dmem_addr_s  = test_normal ? ext_data_addr[DAW-1:0] : alu_res_s[DAW-1:0];
  assign dmem_rdata_s = dmem_r[dmem_addr_s];
  assign dmem_wdata_s = test_normal ? ext_data_data : port_b_s;
  assign dmem_we_s    = clr && (test_normal ? ext_data_write_en : data_write_en);
  assign imem_we_s    = clr && test_normal && ext_instr_we;
  assign rf_we_s      = (RF_write_en || LHI || LLI) && !test_normal;
  assign run_s        = flag_HLT && !test_normal;
  assign pc_inc_s     = pc_r + 16'd1;

  // Write-back source select, first match wins.
  always_comb begin
    if (flag_mem_RF) begin
      wb_data_s = dmem_rdata_s;
    end else if (flag_ALU_RF) begin
      wb_data_s = alu_res_s;
    end else if (flag_Rm_RF) begin
      wb_data_s = port_b_s;
    end else if (flag_PC_RF) begin
      wb_data_s = pc_inc_s;
    end else if (LHI) begin
      wb_data_s = {imm8_s, port_b_s[7:0]};
    end else if (LLI) begin
      wb_data_s = {8'h00, imm8_s};
    end else begin
      wb_data_s = alu_res_s;
    end
  end

  // Next-PC select, first match wins; branch offset is sign-extended imm8.
  always_comb begin
    if (flag_Rm_PC) begin
      next_pc_s = rm_val_s;
    end else if (flag_Rd_PC) begin
      next_pc_s = port_b_s;
    end else if (JMP && flag_label_PC) begin
      next_pc_s = {5'd0, imm11_s};
    end else if (BRANCH) begin
      next_pc_s = pc_r + {{8{imm8_s[7]}}, imm8_s};
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Memory arrays: contents survive reset, writes are blocked while clr is low.
  always_ff @(posedge clk) begin
    if (imem_we_s) begin
      imem_r[ext_instr_addr[IAW-1:0]] <= ext_instr_data;
    end
    if (dmem_we_s) begin
      dmem_r[dmem_addr_s] <= dmem_wdata_s;
    end
  end

  // Architectural state: PC, register file, carry and output register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_r   <= 16'd0;
      outr_r <= 16'd0;
      c_r    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_r[i] <= 16'd0;
      end
    end else begin
      if (run_s) begin
        pc_r <= next_pc_s;
      end
      if (rf_we_s) begin
        rf_r[rd_s] <= wb_data_s;
      end
      if (flag_ALU_RF && RF_write_en && !test_normal) begin
        c_r <= Pre_C;
      end
      if (flag_OutR && !test_normal) begin
        outr_r <= port_a_s;
      end
    end
  end

  assign OutR = outr_r;

  assign unused_s = &{1'b0, ext_instr_addr[15:IAW], ext_data_addr[15:DAW],
                      alu_res_s[15:DAW], instr_s[15:11]};

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed program steps from the test plan,
// then randomized control/data traffic, all checked against a behavioural model.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        clr, flag_HLT, test_normal;
  logic        ext_instr_we, ext_data_write_en;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
  logic [15:0] mem_instr_out, OutR;
  logic        Src_Read_B, Src_ALU_B, ADC, SUB, SBB;
  logic        JMP, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH;
  logic        data_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI;
  logic        RF_write_en, flag_OutR;
  logic        Pre_C, Pre_V, Pre_Z, Pre_N;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_rf   [8];
  logic [15:0] m_pc, m_outr;
  logic        m_c;
  logic [15:0] e_instr, e_a, e_bport, e_res, e_wb, e_npc;
  logic        e_c, e_v, e_z, e_n;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .clr(clr), .flag_HLT(flag_HLT), .test_normal(test_normal),
    .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
    .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
    .mem_instr_out(mem_instr_out), .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .flag_label_PC(flag_label_PC),
    .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC), .BRANCH(BRANCH),
    .data_write_en(data_write_en), .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF),
    .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI),
    .RF_write_en(RF_write_en), .flag_OutR(flag_OutR),
    .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N), .OutR(OutR)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    clr = 1'b1; flag_HLT = 1'b1; test_normal = 1'b0;
    ext_instr_we = 1'b0; ext_data_write_en = 1'b0;
    ext_instr_addr = 16'd0; ext_instr_data = 16'd0; ext_data_addr = 16'd0; ext_data_data = 16'd0;
    Src_Read_B = 1'b0; Src_ALU_B = 1'b0; ADC = 1'b0; SUB = 1'b0; SBB = 1'b0;
    JMP = 1'b0; flag_label_PC = 1'b0; flag_Rm_PC = 1'b0; flag_Rd_PC = 1'b0; BRANCH = 1'b0;
    data_write_en = 1'b0; flag_mem_RF = 1'b0; flag_ALU_RF = 1'b0; flag_Rm_RF = 1'b0;
    flag_PC_RF = 1'b0; LHI = 1'b0; LLI = 1'b0; RF_write_en = 1'b0; flag_OutR = 1'b0;
  endtask

  // Combinational behaviour from the architectural rules, computed with plain integers.
  task automatic model_eval();
    logic [15:0] b, beff;
    logic [2:0]  rd, rn, rm;
    int unsigned usum, cin;
    int          sa, sb, ssum;
    e_instr = test_normal ? m_imem[ext_instr_addr[7:0]] : m_imem[m_pc[7:0]];
    rd = e_instr[10:8]; rn = e_instr[7:5]; rm = e_instr[4:2];
    e_a     = m_rf[rn];
    e_bport = (Src_Read_B || flag_Rd_PC) ? m_rf[rd] : m_rf[rm];
    b       = Src_ALU_B ? {11'd0, e_instr[4:0]} : e_bport;
    beff    = (SUB || SBB) ? ~b : b;
    cin     = SUB ? 32'd1 : ((SBB || ADC) ? {31'd0, m_c} : 32'd0);
    usum    = e_a + beff + cin;
    e_res   = usum[15:0];
    e_c     = usum > 32'd65535;
    sa      = e_a[15]  ? int'(e_a)  - 65536 : int'(e_a);
    sb      = beff[15] ? int'(beff) - 65536 : int'(beff);
    ssum    = sa + sb + int'(cin);
    e_v     = (ssum > 32767) || (ssum < -32768);
    e_z     = (e_res == 16'd0);
    e_n     = e_res[15];
    if (flag_mem_RF)      e_wb = m_dmem[e_res[7:0]];
    else if (flag_ALU_RF) e_wb = e_res;
    else if (flag_Rm_RF)  e_wb = e_bport;
    else if (flag_PC_RF)  e_wb = m_pc + 16'd1;
    else if (LHI)         e_wb = {e_instr[7:0], e_bport[7:0]};
    else if (LLI)         e_wb = {8'h00, e_instr[7:0]};
    else                  e_wb = e_res;
    if (flag_Rm_PC)                  e_npc = m_rf[rm];
    else if (flag_Rd_PC)             e_npc = e_bport;
    else if (JMP && flag_label_PC)   e_npc = {5'd0, e_instr[10:0]};
    else if (BRANCH)                 e_npc = m_pc + {{8{e_instr[7]}}, e_instr[7:0]};
    else                             e_npc = m_pc + 16'd1;
  endtask

  task automatic model_commit();
    if (!clr) begin
      m_pc = 16'd0; m_outr = 16'd0; m_c = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    end else begin
      if (test_normal && ext_instr_we) m_imem[ext_instr_addr[7:0]] = ext_instr_data;
      if (test_normal) begin
        if (ext_data_write_en) m_dmem[ext_data_addr[7:0]] = ext_data_data;
      end else if (data_write_en) begin
        m_dmem[e_res[7:0]] = e_bport;
      end
      if ((RF_write_en || LHI || LLI) && !test_normal) m_rf[e_instr[10:8]] = e_wb;
      if (flag_ALU_RF && RF_write_en && !test_normal) m_c = e_c;
      if (flag_HLT && !test_normal) m_pc = e_npc;
      if (flag_OutR && !test_normal) m_outr = e_a;
    end
  endtask

  // One clock: compare combinational outputs before the edge, OutR after it.
  task automatic tick(input string tag, input bit chk);
    #1;
    model_eval();
    if (chk) begin
      check({tag, ":instr"}, mem_instr_out, e_instr);
      check({tag, ":flags"}, {12'd0, Pre_C, Pre_V, Pre_Z, Pre_N}, {12'd0, e_c, e_v, e_z, e_n});
    end
    @(posedge clk);
    model_commit();
    #1;
    if (chk) check({tag, ":outr"}, OutR, m_outr);
  endtask

  task automatic load_imem(input logic [7:0] addr, input logic [15:0] data);
    clear_ctl();
    test_normal = 1'b1; ext_instr_we = 1'b1;
    ext_instr_addr = {8'd0, addr}; ext_instr_data = data;
    tick("load", 1'b0);
  endtask

  logic [15:0] prog [16];

  initial begin
    prog = '{16'h1900, 16'hE020, 16'h0156, 16'hE020, 16'h0134, 16'h0112, 16'h0221, 16'h0243,
             16'h0328, 16'hE060, 16'h0344, 16'hE060, 16'h0227, 16'hE040, 16'h0227, 16'hE040};
    clear_ctl();
    @(posedge clk); #1;
    clr = 1'b0;
    tick("rst0", 1'b0);
    check("reset_outr", OutR, 16'h0000);

    // Preload both memories in test mode
    for (int i = 0; i < 256; i++) begin
      clear_ctl();
      test_normal = 1'b1; ext_instr_we = 1'b1; ext_data_write_en = 1'b1;
      ext_instr_addr = 16'(i); ext_data_addr = 16'(i);
      ext_instr_data = (i < 16) ? prog[i] : 16'($urandom);
      ext_data_data  = (i == 0) ? 16'h1234 : 16'($urandom);
      tick("preload", 1'b0);
    end

    clear_ctl(); clr = 1'b0; tick("rst1", 1'b1);
    // LDR R1,[R0+0] then OUT R1
    clear_ctl(); Src_ALU_B = 1'b1; flag_mem_RF = 1'b1; RF_write_en = 1'b1; tick("ldr", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_ldr", 1'b1);
    check("ldr_outr", OutR, 16'h1234);
    check("ldr_pc2", mem_instr_out, 16'h0156);
    // LHI R1,0x56 then OUT
    clear_ctl(); Src_Read_B = 1'b1; LHI = 1'b1; RF_write_en = 1'b1; tick("lhi", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_lhi", 1'b1);
    check("lhi_outr", OutR, 16'h5634);
    // Rebuild R1=0x1234, R2=0x4321
    clear_ctl(); LLI = 1'b1; tick("lli_r1", 1'b1);
    clear_ctl(); Src_Read_B = 1'b1; LHI = 1'b1; tick("lhi_r1", 1'b1);
    clear_ctl(); LLI = 1'b1; tick("lli_r2", 1'b1);
    clear_ctl(); Src_Read_B = 1'b1; LHI = 1'b1; tick("lhi_r2", 1'b1);
    // ADD R3=R1+R2
    clear_ctl(); flag_ALU_RF = 1'b1; RF_write_en = 1'b1; tick("add", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_add", 1'b1);
    check("add_outr", OutR, 16'h5555);
    // SUB R3=R2-R1 with flag check
    clear_ctl(); SUB = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1;
    #1;
    check("sub_flags", {12'd0, Pre_C, Pre_V, Pre_Z, Pre_N}, 16'h0008);
    tick("sub", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_sub", 1'b1);
    check("sub_outr", OutR, 16'h30ED);
    // ADDI / SUBI with imm5=7
    clear_ctl(); Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; tick("addi", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_addi", 1'b1);
    check("addi_outr", OutR, 16'h123B);
    clear_ctl(); SUB = 1'b1; Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; tick("subi", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_subi", 1'b1);
    check("subi_outr", OutR, 16'h122D);

    // JAL at PC=1 with imm8=7, then OUT R2 at PC=8
    load_imem(8'd1, 16'h0207);
    load_imem(8'd8, 16'hE040);
    clear_ctl(); clr = 1'b0; tick("rst2", 1'b1);
    clear_ctl(); tick("nop", 1'b1);
    clear_ctl(); BRANCH = 1'b1; flag_PC_RF = 1'b1; RF_write_en = 1'b1; tick("jal", 1'b1);
    check("jal_pc8", mem_instr_out, 16'hE040);
    clear_ctl(); flag_OutR = 1'b1; tick("out_jal", 1'b1);
    check("jal_outr", OutR, 16'h0002);

    // Branch wrap, jump, halt, and test-mode write blocking
    load_imem(8'd0, 16'h00FF);
    load_imem(8'd255, 16'h0008);
    clear_ctl(); clr = 1'b0; tick("rst3", 1'b1);
    clear_ctl(); BRANCH = 1'b1; tick("br_wrap", 1'b1);
    check("br_wrap_pc", mem_instr_out, 16'h0008);
    clear_ctl(); JMP = 1'b1; flag_label_PC = 1'b1; tick("jmp", 1'b1);
    check("jmp_pc8", mem_instr_out, 16'hE040);
    clear_ctl(); flag_HLT = 1'b0; tick("hlt", 1'b1);
    check("hlt_hold", mem_instr_out, 16'hE040);
    clear_ctl(); test_normal = 1'b1; ext_instr_addr = 16'd12; LLI = 1'b1; RF_write_en = 1'b1;
    flag_ALU_RF = 1'b1; tick("tm_rfwe", 1'b1);
    clear_ctl(); flag_OutR = 1'b1; tick("out_tm", 1'b1);
    check("tm_no_rf_write", OutR, 16'h0000);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      clear_ctl();
      clr               = ($urandom_range(63) != 0);
      flag_HLT          = ($urandom_range(3) != 0);
      test_normal       = ($urandom_range(7) == 0);
      ext_instr_we      = $urandom_range(1) == 1;
      ext_data_write_en = $urandom_range(1) == 1;
      ext_instr_addr    = 16'($urandom);
      ext_instr_data    = 16'($urandom);
      ext_data_addr     = 16'($urandom);
      ext_data_data     = 16'($urandom);
      Src_Read_B        = $urandom_range(1) == 1;
      Src_ALU_B         = $urandom_range(1) == 1;
      ADC = ($urandom_range(3) == 0); SUB = ($urandom_range(3) == 0); SBB = ($urandom_range(3) == 0);
      JMP = ($urandom_range(3) == 0); flag_label_PC = ($urandom_range(1) == 1);
      flag_Rm_PC = ($urandom_range(7) == 0); flag_Rd_PC = ($urandom_range(7) == 0);
      BRANCH = ($urandom_range(3) == 0);
      data_write_en = ($urandom_range(3) == 0);
      flag_mem_RF = ($urandom_range(5) == 0); flag_ALU_RF = ($urandom_range(2) == 0);
      flag_Rm_RF = ($urandom_range(5) == 0); flag_PC_RF = ($urandom_range(5) == 0);
      LHI = ($urandom_range(5) == 0); LLI = ($urandom_range(5) == 0);
      RF_write_en = ($urandom_range(1) == 1);
      flag_OutR = ($urandom_range(1) == 1);
      tick("rand", 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
Name: risc_datapath

Overview:
- 16-bit single-cycle RISC datapath: PC, instruction memory, 8×16 register file, ALU with flag generation, data memory, write-back and next-PC muxes, and an output register.
- An external controller decodes `mem_instr_out` and drives all control strobes. Flags `Pre_*` are returned to the controller.
- A test mode (`test_normal=1`) lets the bench load both memories from outside.

Parameters:
- IMEM_DEPTH, 256, instruction-memory words; address = low log2(IMEM_DEPTH) bits.
- DMEM_DEPTH, 256, data-memory words; address = low log2(DMEM_DEPTH) bits.

Ports:
- clk in 1: clock; all state updates on the rising edge.
- clr in 1: synchronous, active-low reset.
- flag_HLT in 1: 1 = run (PC updates); 0 = PC frozen.
- test_normal in 1: 1 = test/load mode; 0 = normal execution.
- ext_instr_we in 1: instruction-memory write enable (test mode).
- ext_instr_addr in 16: instruction-memory address (test mode).
- ext_instr_data in 16: instruction-memory write data.
- ext_data_write_en in 1: data-memory write enable (test mode).
- ext_data_addr in 16: data-memory address (test mode).
- ext_data_data in 16: data-memory write data (test mode).
- mem_instr_out out 16: instruction word at the current instruction-memory address.
- Src_Read_B in 1: selects register-file port-B address; 1 = instr[10:8] (Rd), 0 = instr[4:2] (Rm).
- Src_ALU_B in 1: selects ALU operand B; 1 = zero-extended instr[4:0], 0 = port B.
- ADC, SUB, SBB in 1 each: ALU operation select.
- JMP, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH in 1 each: next-PC select.
- data_write_en in 1: data-memory write in normal mode.
- flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI in 1 each: write-back select.
- RF_write_en in 1: register-file write enable.
- flag_OutR in 1: load OutR.
- Pre_C, Pre_V, Pre_Z, Pre_N out 1 each: combinational ALU flags.
- OutR out 16: output register.

Behaviour:
- Instruction fields:
  - Rd = instr[10:8], Rn = instr[7:5], Rm = instr[4:2].
  - imm5 = instr[4:0], imm8 = instr[7:0], imm11 = instr[10:0].
- Register file:
  - Port A address = Rn.
  - Port B address = Rd when Src_Read_B or flag_Rd_PC is set, else Rm.
  - Reads are asynchronous.
- ALU (A = port A; B = imm5 zero-extended if Src_ALU_B, else port B):
  - SUB: A + ~B + 1.
  - SBB: A + ~B + C.
  - ADC: A + B + C.
  - Otherwise: A + B.
  - Priority SUB > SBB > ADC.
- Flags:
  - Pre_C = carry out (for subtraction, 1 = no borrow).
  - Pre_V = signed overflow.
  - Pre_Z = (result == 0).
  - Pre_N = result[15].
- Internal C register: loads Pre_C on a clock edge with flag_ALU_RF & RF_write_en & !test_normal.
- Data memory:
  - Asynchronous read, synchronous write.
  - Normal mode: address = ALU result, write data = port B, write enable = data_write_en.
  - Test mode: ext_data_addr / ext_data_data / ext_data_write_en; internal writes blocked.
- Instruction memory:
  - Asynchronous read, synchronous write.
  - Address = ext_instr_addr in test mode, else PC.
  - Writes only when test_normal & ext_instr_we.
- Write-back data, first match wins:
  1. flag_mem_RF: memory read data.
  2. flag_ALU_RF: ALU result.
  3. flag_Rm_RF: port B.
  4. flag_PC_RF: PC+1.
  5. LHI: {imm8, portB[7:0]}.
  6. LLI: {8'h00, imm8}.
  7. Default: ALU result.
- Register-file write on the clock edge when (RF_write_en | LHI | LLI) & !test_normal; destination is Rd.
- Next PC, first match wins:
  1. flag_Rm_PC: R[Rm].
  2. flag_Rd_PC: port B.
  3. JMP & flag_label_PC: {5'b0, imm11}.
  4. BRANCH: PC + sign-extended imm8.
  5. Default: PC+1.
  - Update only when flag_HLT & !test_normal; all arithmetic is mod 2^16.
- OutR loads port A on the clock edge when flag_OutR & !test_normal; otherwise it holds.
- Reset (clr=0 at a clock edge) dominates everything:
  - PC = 0, all registers = 0, OutR = 0, C = 0.
  - Memory contents are preserved.
  - A reset in mid-program restarts at address 0.

Test Plan:
- Load imem[0]=0x1900 (LDR R1,[R0+0]), imem[1]=0xE020 (OUT R1) and dmem[0]=0x1234. Pulse clr low, then run LDR then OUT controls -> OutR=0x1234, PC=2.
- Load R1=0x1234, then LHI R1,0x56 (Src_Read_B, LHI, RF_write_en), then OUT -> OutR=0x5634.
- Load R1=0x1234 and R2=0x4321, then ADD R3=R1+R2 -> 0x5555. SUB R3=R2-R1 -> 0x30ED, with Pre_C=1, Pre_Z=0, Pre_N=0, Pre_V=0.
- ADDI R2=R1+7 with R1=0x1234 -> 0x123B; SUBI R2=R1-7 -> 0x122D.
- At PC=1 run a JAL-style instruction with imm8=7 (BRANCH, flag_PC_RF, RF_write_en, Rd=R2) -> PC=8, R2=0x0002; OUT R2 -> OutR=0x0002.
- Branch and jump boundaries:
  - BRANCH with imm8=0xFF at PC=0 -> PC=0xFFFF (wrap).
  - JMP with imm11=8 -> PC=8.
  - flag_HLT=0 -> PC holds.
  - test_normal=1 with RF_write_en=1 -> no register change.
